// File: rtl/vga_cfg_pkg.sv
// vga_cfg_pkg: register offsets, timing-word field layout and pack/unpack helpers.
// Used by the VGA config slave. The timing word is 64 bits wide, and bit 63 is reserved.
package vga_cfg_pkg;
  localparam int TIMING_W = 64;
  localparam int CTRL_OFF = 'h00;
  localparam int STATUS_OFF = 'h04;
  localparam int BASE_OFF = 'h08;
  localparam int TOP_OFF = 'h0C;
  localparam int PRESET_OFF = 'h10;
  localparam int HSYNC_END_LSB = 0, HSYNC_END_MSB = 10;
  localparam int HPULSE_END_LSB = 11, HPULSE_END_MSB = 18;
  localparam int HDATA_BEGIN_LSB = 19, HDATA_BEGIN_MSB = 26;
  localparam int HDATA_END_LSB = 27, HDATA_END_MSB = 36;
  localparam int VSYNC_END_LSB = 37, VSYNC_END_MSB = 45;
  localparam int VPULSE_END_LSB = 46, VPULSE_END_MSB = 48;
  localparam int VDATA_BEGIN_LSB = 49, VDATA_BEGIN_MSB = 53;
  localparam int VDATA_END_LSB = 54, VDATA_END_MSB = 62;
  typedef struct packed {
    logic [8:0] vdata_end;
    logic [4:0] vdata_begin;
    logic [2:0] vpulse_end;
    logic [8:0] vsync_end;
    logic [9:0] hdata_end;
    logic [7:0] hdata_begin;
    logic [7:0] hpulse_end;
    logic [10:0] hsync_end;
  } timing_t;
  function automatic logic [TIMING_W-1:0] timing_pack(timing_t t);
    logic [TIMING_W-1:0] w;
    w = '0;
    w[HSYNC_END_MSB:HSYNC_END_LSB] = t.hsync_end;
    w[HPULSE_END_MSB:HPULSE_END_LSB] = t.hpulse_end;
    w[HDATA_BEGIN_MSB:HDATA_BEGIN_LSB] = t.hdata_begin;
    w[HDATA_END_MSB:HDATA_END_LSB] = t.hdata_end;
    w[VSYNC_END_MSB:VSYNC_END_LSB] = t.vsync_end;
    w[VPULSE_END_MSB:VPULSE_END_LSB] = t.vpulse_end;
    w[VDATA_BEGIN_MSB:VDATA_BEGIN_LSB] = t.vdata_begin;
    w[VDATA_END_MSB:VDATA_END_LSB] = t.vdata_end;
    return w;
  endfunction
  function automatic timing_t timing_unpack(logic [TIMING_W-2:0] w);
    timing_t t;
    t.hsync_end = w[HSYNC_END_MSB:HSYNC_END_LSB];
    t.hpulse_end = w[HPULSE_END_MSB:HPULSE_END_LSB];
    t.hdata_begin = w[HDATA_BEGIN_MSB:HDATA_BEGIN_LSB];
    t.hdata_end = w[HDATA_END_MSB:HDATA_END_LSB];
    t.vsync_end = w[VSYNC_END_MSB:VSYNC_END_LSB];
    t.vpulse_end = w[VPULSE_END_MSB:VPULSE_END_LSB];
    t.vdata_begin = w[VDATA_BEGIN_MSB:VDATA_BEGIN_LSB];
    t.vdata_end = w[VDATA_END_MSB:VDATA_END_LSB];
    return t;
  endfunction
endpackage

// File: rtl/vga_cfg_regs_if.sv
// vga_cfg_regs_if: APB3 bus bundle used by the VGA config slave.
// The master drives paddr, pwdata, psel, penable and pwrite. The slave drives pready, prdata and pslverr.
interface vga_cfg_regs_if #(parameter int ADDR_WIDTH = 12, parameter int DATA_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic psel;
  logic penable;
  logic pwrite;
  logic pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic pslverr;
  modport master (output paddr, pwdata, psel, penable, pwrite, input pready, prdata, pslverr);
  modport slave (input paddr, pwdata, psel, penable, pwrite, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB handshake with one wait state.
// Inputs are clk, resetn, the APB control signals, err_i (decode error) and rdata_i (read mux).
// Outputs are the registered pready/pslverr/prdata and the single-cycle wr_en_o/rd_en_o strobes.
module apb_wait_slave (
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic        err_i,
  input  logic [31:0] rdata_i,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] prdata_o,
  output logic        wr_en_o,
  output logic        rd_en_o
);
  logic req, pready_d, pready_q, pslverr_d, pslverr_q;
  logic [31:0] prdata_d, prdata_q;
  always_comb begin
    req = psel_i & penable_i & ~pready_q;
    wr_en_o = req & pwrite_i & ~err_i;
    rd_en_o = req & ~pwrite_i;
    pready_d = req;
    pslverr_d = req & err_i;
    prdata_d = req ? (err_i ? '0 : rdata_i) : prdata_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
    end
  end
  assign pready_o = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o = prdata_q;
endmodule

// File: rtl/vga_cfg_regs.sv
// vga_cfg_regs: APB3 config slave holding the timing presets and the staged framebuffer window for the VGA subsystem.
// Ports: clk and resetn (synchronous, active-low); apb (slave modport); frame_start_i (frame pulse).
// Outputs: the active enable, the horizontal and vertical timing fields, base/top, and commit_o (pulses when the active set loads).
module vga_cfg_regs import vga_cfg_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PRESETS = 4,
  parameter int FB_ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  vga_cfg_regs_if.slave            apb,
  input  logic                     frame_start_i,
  output logic                     vga_en_o,
  output logic [10:0]              hsync_end_o,
  output logic [7:0]               hpulse_end_o,
  output logic [7:0]               hdata_begin_o,
  output logic [9:0]               hdata_end_o,
  output logic [8:0]               vsync_end_o,
  output logic [2:0]               vpulse_end_o,
  output logic [4:0]               vdata_begin_o,
  output logic [8:0]               vdata_end_o,
  output logic [FB_ADDR_WIDTH-1:0] base_addr_o,
  output logic [FB_ADDR_WIDTH-1:0] top_addr_o,
  output logic                     commit_o
);
  localparam int IW = $clog2(NUM_PRESETS);
  logic enable_d, enable_q, pending_d, pending_q, act_en_d, act_en_q, commit_d, commit_q;
  logic [3:0] sel_d, sel_q;
  logic [15:0] frame_cnt_d, frame_cnt_q;
  logic [FB_ADDR_WIDTH-1:0] base_d, base_q, top_d, top_q, act_base_d, act_base_q, act_top_d, act_top_q;
  timing_t preset_d [NUM_PRESETS];
  timing_t preset_q [NUM_PRESETS];
  timing_t act_timing_d, act_timing_q;
  logic [ADDR_WIDTH-1:0] pidx;
  logic [IW-1:0] pi;
  logic is_ctrl, is_status, is_base, is_top, is_preset, hi, err, load, wr_en, rd_en;
  logic [TIMING_W-1:0] rd_word, wr_word;
  logic [DATA_WIDTH-1:0] rdata;
  apb_wait_slave u_apb (
    .clk(clk), .resetn(resetn), .psel_i(apb.psel), .penable_i(apb.penable), .pwrite_i(apb.pwrite),
    .err_i(err), .rdata_i(rdata), .pready_o(apb.pready), .pslverr_o(apb.pslverr), .prdata_o(apb.prdata),
    .wr_en_o(wr_en), .rd_en_o(rd_en)
  );
  always_comb begin
    pidx = (apb.paddr - ADDR_WIDTH'(PRESET_OFF)) >> 3;
    pi = pidx[IW-1:0];
    hi = apb.paddr[2];
    is_ctrl = apb.paddr == ADDR_WIDTH'(CTRL_OFF);
    is_status = apb.paddr == ADDR_WIDTH'(STATUS_OFF);
    is_base = apb.paddr == ADDR_WIDTH'(BASE_OFF);
    is_top = apb.paddr == ADDR_WIDTH'(TOP_OFF);
    is_preset = apb.paddr >= ADDR_WIDTH'(PRESET_OFF) && pidx < ADDR_WIDTH'(NUM_PRESETS);
    err = apb.paddr[1:0] != 2'b00 || !(is_ctrl || is_status || is_base || is_top || is_preset) ||
          (apb.pwrite && (is_status || (is_ctrl && 5'(apb.pwdata[7:4]) >= 5'(NUM_PRESETS))));
    rd_word = timing_pack(preset_q[pi]);
    wr_word = hi ? {apb.pwdata, rd_word[31:0]} : {rd_word[63:32], apb.pwdata};
    rdata = !rd_en ? '0 : is_ctrl ? {23'b0, 1'b0, sel_q, 3'b0, enable_q} :
            is_status ? {frame_cnt_q, 15'b0, pending_q} : is_base ? 32'(base_q) :
            is_top ? 32'(top_q) : hi ? rd_word[63:32] : rd_word[31:0];
    // A commit raised in this cycle is not yet in pending_q, so it waits for the next frame_start_i.
    load = pending_q & (frame_start_i | ~act_en_q);
    commit_d = load;
    pending_d = pending_q & ~load;
    frame_cnt_d = frame_cnt_q + 16'(frame_start_i);
    enable_d = enable_q;
    sel_d = sel_q;
    base_d = base_q;
    top_d = top_q;
    preset_d = preset_q;
    act_en_d = load ? enable_q : act_en_q;
    act_timing_d = load ? preset_q[sel_q[IW-1:0]] : act_timing_q;
    act_base_d = load ? base_q : act_base_q;
    act_top_d = load ? top_q : act_top_q;
    if (wr_en && is_ctrl) begin
      enable_d = apb.pwdata[0];
      sel_d = apb.pwdata[7:4];
      pending_d = pending_d | apb.pwdata[8];
      // Disabling takes effect at once and does not wait for a frame boundary.
      if (!apb.pwdata[0]) act_en_d = 1'b0;
    end
    if (wr_en && is_base) base_d = apb.pwdata[FB_ADDR_WIDTH-1:0];
    if (wr_en && is_top) top_d = apb.pwdata[FB_ADDR_WIDTH-1:0];
    if (wr_en && is_preset) preset_d[pi] = timing_unpack(wr_word[TIMING_W-2:0]);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      enable_q <= 1'b0;
      sel_q <= '0;
      pending_q <= 1'b0;
      base_q <= '0;
      top_q <= '0;
      preset_q <= '{default: '0};
      act_en_q <= 1'b0;
      act_timing_q <= '0;
      act_base_q <= '0;
      act_top_q <= '0;
      commit_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      enable_q <= enable_d;
      sel_q <= sel_d;
      pending_q <= pending_d;
      base_q <= base_d;
      top_q <= top_d;
      preset_q <= preset_d;
      act_en_q <= act_en_d;
      act_timing_q <= act_timing_d;
      act_base_q <= act_base_d;
      act_top_q <= act_top_d;
      commit_q <= commit_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign vga_en_o = act_en_q;
  assign hsync_end_o = act_timing_q.hsync_end;
  assign hpulse_end_o = act_timing_q.hpulse_end;
  assign hdata_begin_o = act_timing_q.hdata_begin;
  assign hdata_end_o = act_timing_q.hdata_end;
  assign vsync_end_o = act_timing_q.vsync_end;
  assign vpulse_end_o = act_timing_q.vpulse_end;
  assign vdata_begin_o = act_timing_q.vdata_begin;
  assign vdata_end_o = act_timing_q.vdata_end;
  assign base_addr_o = act_base_q;
  assign top_addr_o = act_top_q;
  assign commit_o = commit_q;
endmodule

// File: tb/tb_vga_cfg_regs.sv
// tb_vga_cfg_regs: scoreboard testbench for vga_cfg_regs, checked against a register-level reference model.
module tb_vga_cfg_regs;
  localparam int NP = 4;
  logic clk = 1'b0, resetn = 1'b0, frame_start = 1'b0;
  logic vga_en, commit;
  logic [10:0] hsync_end;
  logic [7:0] hpulse_end, hdata_begin;
  logic [9:0] hdata_end;
  logic [8:0] vsync_end, vdata_end;
  logic [2:0] vpulse_end;
  logic [4:0] vdata_begin;
  logic [31:0] base_addr, top_addr;
  vga_cfg_regs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  vga_cfg_regs #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_PRESETS(NP), .FB_ADDR_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .apb(bus), .frame_start_i(frame_start), .vga_en_o(vga_en),
    .hsync_end_o(hsync_end), .hpulse_end_o(hpulse_end), .hdata_begin_o(hdata_begin), .hdata_end_o(hdata_end),
    .vsync_end_o(vsync_end), .vpulse_end_o(vpulse_end), .vdata_begin_o(vdata_begin), .vdata_end_o(vdata_end),
    .base_addr_o(base_addr), .top_addr_o(top_addr), .commit_o(commit)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, n_commit = 0, m_commits = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {logic [31:0] rdata; logic err; logic [11:0] addr;} resp_t;
  resp_t sb[$];
  resp_t r;
  always @(negedge clk) begin
    if (commit === 1'b1) n_commit++;
    if (bus.pready === 1'b1) begin
      if (sb.size() == 0) check("unexpected pready", 1, 0);
      else begin
        r = sb.pop_front();
        check($sformatf("prdata@%0h", r.addr), bus.prdata, r.rdata);
        check($sformatf("pslverr@%0h", r.addr), bus.pslverr, r.err);
      end
    end
  end
  logic m_en, m_pend, a_en;
  int m_sel;
  logic [15:0] m_fcnt;
  logic [31:0] m_base, m_top, a_base, a_top;
  logic [63:0] m_pre [NP];
  logic [63:0] a_tim;
  task automatic m_load();
    a_en = m_en;
    a_tim = m_pre[m_sel];
    a_base = m_base;
    a_top = m_top;
    m_pend = 1'b0;
    m_commits++;
  endtask
  task automatic model_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d, output logic [31:0] rd, output logic er);
    int off, idx;
    off = int'(a);
    rd = 0;
    er = 0;
    if (off % 4 != 0) er = 1;
    else if (off == 0) begin
      if (!wr) rd = 32'(m_sel * 16) | 32'(m_en);
      else if (int'(d[7:4]) >= NP) er = 1;
      else begin
        m_en = d[0];
        m_sel = int'(d[7:4]);
        if (d[8]) m_pend = 1'b1;
        if (!d[0]) a_en = 1'b0;
      end
    end else if (off == 4) begin
      if (wr) er = 1;
      else rd = {m_fcnt, 15'b0, m_pend};
    end else if (off == 8) begin
      if (wr) m_base = d;
      else rd = m_base;
    end else if (off == 12) begin
      if (wr) m_top = d;
      else rd = m_top;
    end else if (off >= 16 && (off - 16) / 8 < NP) begin
      idx = (off - 16) / 8;
      if ((off - 16) % 8 == 4) begin
        if (wr) m_pre[idx][63:32] = d & 32'h7FFF_FFFF;
        else rd = m_pre[idx][63:32];
      end else begin
        if (wr) m_pre[idx][31:0] = d;
        else rd = m_pre[idx][31:0];
      end
    end else er = 1;
    if (er) rd = 0;
  endtask
  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic fs = 1'b0);
    logic [31:0] rd;
    logic er;
    int n;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    frame_start = fs;
    if (fs) begin
      m_fcnt++;
      if (m_pend) m_load();
    end
    model_xfer(wr, a, d, rd, er);
    sb.push_back('{rd, er, a});
    n = 0;
    do begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      n++;
    end while (bus.pready !== 1'b1 && n < 8);
    check("pready latency", 64'(n), 1);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    check("pready one cycle", bus.pready, 0);
    check("pslverr drop", bus.pslverr, 0);
    if (m_pend && !a_en) m_load();
  endtask
  task automatic frame();
    logic exp;
    @(posedge clk); #1;
    frame_start = 1'b1;
    exp = m_pend;
    m_fcnt++;
    if (m_pend) m_load();
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("commit_o after frame", commit, exp);
  endtask
  task automatic check_active();
    @(negedge clk); #1;
    check("vga_en_o", vga_en, a_en);
    check("hsync_end_o", hsync_end, a_tim & 64'h7FF);
    check("hpulse_end_o", hpulse_end, (a_tim >> 11) & 64'hFF);
    check("hdata_begin_o", hdata_begin, (a_tim >> 19) & 64'hFF);
    check("hdata_end_o", hdata_end, (a_tim >> 27) & 64'h3FF);
    check("vsync_end_o", vsync_end, (a_tim >> 37) & 64'h1FF);
    check("vpulse_end_o", vpulse_end, (a_tim >> 46) & 64'h7);
    check("vdata_begin_o", vdata_begin, (a_tim >> 49) & 64'h1F);
    check("vdata_end_o", vdata_end, (a_tim >> 54) & 64'h1FF);
    check("base_addr_o", base_addr, a_base);
    check("top_addr_o", top_addr, a_top);
    check("commit count", 64'(n_commit), 64'(m_commits));
  endtask
  task automatic read_all();
    apb_xfer(0, 12'h000, 0);
    apb_xfer(0, 12'h004, 0);
    apb_xfer(0, 12'h008, 0);
    apb_xfer(0, 12'h00C, 0);
    for (int i = 0; i < 2 * NP; i++) apb_xfer(0, 12'(16 + 4 * i), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] w;
    int op;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    m_en = 0; m_pend = 0; a_en = 0; m_sel = 0; m_fcnt = 0;
    m_base = 0; m_top = 0; a_base = 0; a_top = 0; a_tim = 0;
    foreach (m_pre[i]) m_pre[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pready", bus.pready, 0);
    check("reset pslverr", bus.pslverr, 0);
    check("reset prdata", bus.prdata, 0);
    resetn = 1'b1;
    check_active();
    read_all();
    @(posedge clk); #1;
    frame_start = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    frame_start = 1'b0;
    m_fcnt = 16'hFFFF;
    apb_xfer(0, 12'h004, 0);
    frame();
    apb_xfer(0, 12'h004, 0);
    apb_xfer(1, 12'h008, 32'h8000_0000);
    apb_xfer(1, 12'h00C, 32'h8004_B000);
    apb_xfer(1, 12'h000, 32'h101);
    check_active();
    apb_xfer(0, 12'h004, 0);
    w = 64'd799 | (64'd783 << 27);
    apb_xfer(1, 12'h020, w[31:0]);
    apb_xfer(1, 12'h024, w[63:32]);
    apb_xfer(1, 12'h000, 32'h121);
    check_active();
    apb_xfer(0, 12'h004, 0);
    frame();
    check_active();
    apb_xfer(1, 12'h018, 32'h1234_5678);
    apb_xfer(1, 12'h01C, 32'hFFFF_FFFF);
    apb_xfer(1, 12'h000, 32'h111, 1'b1);
    check_active();
    apb_xfer(0, 12'h004, 0);
    frame();
    check_active();
    apb_xfer(0, 12'h006, 0);
    apb_xfer(1, 12'h006, 32'hFFFF_FFFF);
    apb_xfer(0, 12'h200, 0);
    apb_xfer(1, 12'h200, 32'hFFFF_FFFF);
    apb_xfer(0, 12'(16 + 8 * NP), 0);
    apb_xfer(1, 12'(16 + 8 * NP), 32'hDEAD_BEEF);
    apb_xfer(1, 12'h004, 32'hFFFF_FFFF);
    apb_xfer(1, 12'h000, 32'(NP * 16) | 32'h100);
    check_active();
    read_all();
    apb_xfer(1, 12'h000, 32'h020);
    check_active();
    for (int k = 0; k < 250; k++) begin
      op = $urandom_range(0, 8);
      if (op <= 3) apb_xfer(1, 12'(16 + 4 * $urandom_range(0, 2 * NP - 1)), $urandom);
      else if (op == 4) apb_xfer(1, 12'(8 + 4 * $urandom_range(0, 1)), $urandom);
      else if (op == 5) apb_xfer(1, 12'h000, {23'b0, 1'($urandom), 4'($urandom_range(0, NP - 1)), 3'($urandom), 1'($urandom)});
      else if (op == 6) apb_xfer(0, 12'(4 * $urandom_range(0, 3 + 2 * NP)), 0);
      else if (op == 7) apb_xfer(1'($urandom), 12'($urandom), $urandom);
      else frame();
      check_active();
    end
    repeat (5) @(posedge clk);
    check("scoreboard drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_cfg_regs.md
Name: vga_cfg_regs

Overview:
APB3 configuration slave for the VGA subsystem, replacing the fixed four-entry config block. It holds a parameterised table of software-programmable timing presets and staged framebuffer base/top addresses. An active copy of these drives the VGA control unit and the ping-pong register. Staged changes commit atomically at a frame boundary, so outputs never change mid-frame.

Parameters:
ADDR_WIDTH, 12, APB address width (byte address)
DATA_WIDTH, 32, APB data width; only 32 supported
NUM_PRESETS, 4, number of timing presets, 2..16
FB_ADDR_WIDTH, 32, framebuffer address width (≤32)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
paddr_i  in  ADDR_WIDTH  APB byte address
pwdata_i  in  32  APB write data
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
pready_o  out  1  APB ready
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
frame_start_i  in  1  1-cycle pulse from control unit at frame start
vga_en_o  out  1  active enable
hsync_end_o/hpulse_end_o/hdata_begin_o/hdata_end_o  out  11/8/8/10  active horizontal timing
vsync_end_o/vpulse_end_o/vdata_begin_o/vdata_end_o  out  9/3/5/9  active vertical timing
base_addr_o/top_addr_o  out  FB_ADDR_WIDTH  active framebuffer window
commit_o  out  1  1-cycle pulse when the active set updates

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. All outputs, staging registers, presets, the active set and the frame counter reset to 0.
- APB: one wait state per transfer.
  - In the first cycle with psel_i&penable_i&!pready_o, the block registers pready_o=1 for exactly one cycle.
  - Writes take effect, and prdata_o/pslverr_o are valid, in that pready_o cycle.
  - Next cycle: pready_o=0, pslverr_o=0. prdata_o holds its value.
- Error: pslverr_o=1 for any of: paddr_i[1:0]≠0; unmapped offset; preset index ≥NUM_PRESETS; write to STATUS. An errored write has no side effects; an errored read returns 0.
- Register map (byte offsets):
  - 0x00 CTRL RW: [0] enable, [4+:4] preset_sel (staged), [8] commit (write-1 sets commit_pending; reads 0).
  - 0x04 STATUS RO: [0] commit_pending, [31:16] frame_cnt.
  - 0x08 BASE RW (staged).
  - 0x0C TOP RW (staged).
  - 0x10+8i PRESET_LO[i] = timing[31:0]; 0x14+8i PRESET_HI[i] = timing[63:32], RW.
  - preset_sel ≥NUM_PRESETS: that CTRL write gets pslverr_o=1 and is fully discarded.
- Timing word packing: hsync_end[10:0], hpulse_end[18:11], hdata_begin[26:19], hdata_end[36:27], vsync_end[45:37], vpulse_end[48:46], vdata_begin[53:49], vdata_end[62:54]; bit 63 is reserved, reads 0.
- Commit:
  - Active set = {enable, timing copy of preset[preset_sel], base, top}.
  - Load condition: commit_pending=1 AND (frame_start_i=1 OR active vga_en_o=0). On load, the active set loads on the next clk edge, commit_o pulses the same cycle the outputs change, and commit_pending clears.
  - Exception: a CTRL.enable 1→0 write applies to vga_en_o immediately, without a commit.
  - Preset table writes never affect outputs directly; the active timing is a copy latched at commit.
- Simultaneous events:
  - A commit-setting write in the same cycle as frame_start_i is not committed by that pulse; it waits for the next frame_start_i (or the next cycle if vga_en_o=0).
  - Writes to staging while pending: the latest value is committed.
- frame_cnt increments on every frame_start_i and wraps 0xFFFF→0.
- Reset mid-transfer: pready_o drops to 0 and the transfer is abandoned; the master must restart.

Decomposition:
- Package vga_cfg_pkg holds:
  - register offset constants;
  - timing field LSB/MSB constants;
  - TIMING_W=64;
  - a timing struct typedef with pack/unpack functions.
- Sub-module apb_wait_slave generates the one-wait-state pready/pslverr handshake and the wr_en/rd_en strobes. The register file and commit logic stay in vga_cfg_regs.

Test Plan:
- Reset, then read every mapped register → all 0, pslverr_o=0, each pready_o high exactly one cycle, 2nd access cycle.
- Write BASE=0x8000_0000, TOP=0x8004_B000, CTRL=0x101 (enable, sel 0, commit) with vga_en_o=0 → active updates the next cycle, commit_o pulses once, STATUS[0]=0.
- With vga_en_o=1: write PRESET_LO[2]/PRESET_HI[2] (hsync_end=799, hdata_end=783), then CTRL=0x121 → outputs unchanged and STATUS[0]=1 until frame_start_i; the cycle after the pulse hsync_end_o=799 and commit_o=1.
- Commit write in the same cycle as frame_start_i → no update; next frame_start_i updates.
- Access 0x06, 0x200, PRESET index NUM_PRESETS, write STATUS, CTRL sel=NUM_PRESETS → pslverr_o=1, no state change.
- Issue 65536 frame_start_i pulses → frame_cnt returns to 0.
